// File: rtl/mem_wb_pipe.sv
// MEM->WB elastic pipeline register: 2-entry skid buffer, flush,
// WB result select and retired-instruction counter.
module mem_wb_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid_M,
  output logic                  o_ready_M,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_alu_result_M,
  input  logic [DATA_WIDTH-1:0] i_read_data_M,
  input  logic [DATA_WIDTH-1:0] i_pc_target_M,
  input  logic [DATA_WIDTH-1:0] i_pc_plus4_M,
  input  logic [REG_WIDTH-1:0]  i_rd_M,
  input  logic                  i_reg_write_M,
  input  logic [1:0]            i_result_src_M,
  output logic                  o_valid_WB,
  input  logic                  i_ready_WB,
  output logic [DATA_WIDTH-1:0] o_alu_result_WB,
  output logic [DATA_WIDTH-1:0] o_read_data_WB,
  output logic [DATA_WIDTH-1:0] o_pc_target_WB,
  output logic [DATA_WIDTH-1:0] o_pc_plus4_WB,
  output logic [REG_WIDTH-1:0]  o_rd_WB,
  output logic                  o_reg_write_WB,
  output logic [1:0]            o_result_src_WB,
  output logic [DATA_WIDTH-1:0] o_result_WB,
  output logic [CNT_WIDTH-1:0]  o_retire_cnt
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] rdd;
    logic [DATA_WIDTH-1:0] tgt;
    logic [DATA_WIDTH-1:0] pc4;
    logic [REG_WIDTH-1:0]  rd;
    logic                  rw;
    logic [1:0]            src;
  } slot_t;

  // Encoding is {main_valid, skid_valid}
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  slot_t  r_main;
  slot_t  r_skid;
  slot_t  w_in;
  logic   [CNT_WIDTH-1:0] r_cnt;
  logic   w_ready;
  logic   w_accept;
  logic   w_drain;
  logic   w_ld_main_in;
  logic   w_ld_main_skid;
  logic   w_ld_skid;

  assign w_in = '{
    alu: i_alu_result_M,
    rdd: i_read_data_M,
    tgt: i_pc_target_M,
    pc4: i_pc_plus4_M,
    rd:  i_rd_M,
    rw:  i_reg_write_M,
    src: i_result_src_M
  };

  assign w_ready  = ~r_state[0];
  assign w_accept = i_valid_M & w_ready;
  assign w_drain  = r_state[1] & i_ready_WB;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt  = S_ONE;
          w_ld_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_drain) begin
          w_ld_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_FULL;
          w_ld_skid   = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_drain) begin
          w_state_nxt    = S_ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Flush wins; a same-cycle accept is simply dropped
    if (i_flush) begin
      w_state_nxt    = S_EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= w_in;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    o_result_WB = '0;
    unique case (r_main.src)
      2'b00: o_result_WB = r_main.alu;
      2'b01: o_result_WB = r_main.rdd;
      2'b10: o_result_WB = r_main.pc4;
      2'b11: o_result_WB = r_main.tgt;
      default: o_result_WB = '0;
    endcase
  end

  assign o_ready_M       = w_ready;
  assign o_valid_WB      = r_state[1];
  assign o_alu_result_WB = r_main.alu;
  assign o_read_data_WB  = r_main.rdd;
  assign o_pc_target_WB  = r_main.tgt;
  assign o_pc_plus4_WB   = r_main.pc4;
  assign o_rd_WB         = r_main.rd;
  assign o_reg_write_WB  = r_main.rw & r_state[1];
  assign o_result_src_WB = r_main.src;
  assign o_retire_cnt    = r_cnt;

endmodule
